// File: rtl/bp_be_pkg.sv
// bp_be_pkg: backend types shared by the late writeback arbiter and its buffers.
package bp_be_pkg;

    typedef enum logic {e_bp_default_cfg} bp_params_e;

    localparam int dword_width_gp    = 64;
    localparam int reg_addr_width_gp = 5;
    localparam int fflags_width_gp   = 5;

    typedef enum logic {e_late_src_long, e_late_src_mem} bp_be_late_src_e;

    typedef struct packed {
        logic                         ird_w_v;
        logic                         frd_w_v;
        logic [reg_addr_width_gp-1:0] rd_addr;
        logic [dword_width_gp-1:0]    rd_data;
        logic                         fflags_w_v;
        logic [fflags_width_gp-1:0]   fflags;
    } bp_be_wb_pkt_s;

    function automatic int bp_dword_width(bp_params_e cfg);
        return (cfg == e_bp_default_cfg) ? dword_width_gp : 0;
    endfunction

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// bp_be_late_wb_fifo: small 1r1w buffer, ready/valid in and valid/yumi out.
module bp_be_late_wb_fifo
    import bp_be_pkg::*;
#(
    parameter int els_p   = 2,
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rptr;
    logic [ptr_w_lp-1:0] r_wptr;
    logic                r_full;
    logic [ptr_w_lp-1:0] w_wptr_nxt;
    logic                w_empty;
    logic                w_enq;
    logic                w_deq;

    assign w_empty    = (r_rptr == r_wptr) && !r_full;
    assign w_wptr_nxt = r_wptr + 1'b1;
    assign w_enq      = v_i && !r_full;
    assign w_deq      = yumi_i && !w_empty;
    assign ready_o    = !r_full;
    assign v_o        = !w_empty;
    assign data_o     = r_mem[r_rptr];

    // Full only changes when occupancy changes; enq+deq together leaves it alone.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_enq) r_wptr <= w_wptr_nxt;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            if (w_enq != w_deq) r_full <= w_enq && (w_wptr_nxt == r_rptr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// bp_be_late_wb_arbiter: merges long-pipe and memory late results into one
// round-robin writeback stream, holding the granted packet until yumi.
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p     = e_bp_default_cfg,
    parameter int         fifo_els_p      = 2,
    localparam int        dword_width_lp  = bp_dword_width(bp_params_p),
    localparam int        wb_pkt_width_lp = $bits(bp_be_wb_pkt_s)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         long_v_i,
    output logic                         long_ready_o,
    input  logic [reg_addr_width_gp-1:0] long_rd_addr_i,
    input  logic                         long_ird_w_v_i,
    input  logic                         long_frd_w_v_i,
    input  logic [dword_width_lp-1:0]    long_data_i,
    input  logic                         long_fflags_w_v_i,
    input  logic [4:0]                   long_fflags_i,
    input  logic                         mem_v_i,
    output logic                         mem_ready_o,
    input  logic [reg_addr_width_gp-1:0] mem_rd_addr_i,
    input  logic                         mem_ird_w_v_i,
    input  logic                         mem_frd_w_v_i,
    input  logic [dword_width_lp-1:0]    mem_data_i,
    output logic                         late_wb_v_o,
    output logic [wb_pkt_width_lp-1:0]   late_wb_pkt_o,
    input  logic                         late_wb_yumi_i,
    output logic                         busy_o
);

    bp_be_wb_pkt_s              w_long_in;
    bp_be_wb_pkt_s              w_mem_in;
    logic [wb_pkt_width_lp-1:0] w_long_head;
    logic [wb_pkt_width_lp-1:0] w_mem_head;
    logic                       w_long_v;
    logic                       w_mem_v;
    logic                       w_long_yumi;
    logic                       w_mem_yumi;
    bp_be_late_src_e            w_sel;
    bp_be_late_src_e            r_sel;
    bp_be_late_src_e            r_last_grant;
    logic                       r_lock;

    assign w_long_in = '{ird_w_v: long_ird_w_v_i, frd_w_v: long_frd_w_v_i,
                         rd_addr: long_rd_addr_i, rd_data: long_data_i,
                         fflags_w_v: long_fflags_w_v_i, fflags: long_fflags_i};
    assign w_mem_in  = '{ird_w_v: mem_ird_w_v_i, frd_w_v: mem_frd_w_v_i,
                         rd_addr: mem_rd_addr_i, rd_data: mem_data_i,
                         fflags_w_v: 1'b0, fflags: '0};

    bp_be_late_wb_fifo #(.els_p(fifo_els_p), .width_p(wb_pkt_width_lp)) long_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (long_v_i),
        .ready_o (long_ready_o),
        .data_i  (w_long_in),
        .v_o     (w_long_v),
        .data_o  (w_long_head),
        .yumi_i  (w_long_yumi)
    );

    bp_be_late_wb_fifo #(.els_p(fifo_els_p), .width_p(wb_pkt_width_lp)) mem_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (mem_v_i),
        .ready_o (mem_ready_o),
        .data_i  (w_mem_in),
        .v_o     (w_mem_v),
        .data_o  (w_mem_head),
        .yumi_i  (w_mem_yumi)
    );

    // A locked grant wins over round-robin so the offered packet never changes before yumi.
    assign w_sel = r_lock ? r_sel
                 : (w_long_v && w_mem_v) ? ((r_last_grant == e_late_src_mem) ? e_late_src_long : e_late_src_mem)
                 : w_long_v ? e_late_src_long : e_late_src_mem;

    assign late_wb_v_o   = w_long_v || w_mem_v;
    assign busy_o        = w_long_v || w_mem_v;
    assign late_wb_pkt_o = !late_wb_v_o ? '0 : (w_sel == e_late_src_long) ? w_long_head : w_mem_head;
    assign w_long_yumi   = late_wb_yumi_i && (w_sel == e_late_src_long);
    assign w_mem_yumi    = late_wb_yumi_i && (w_sel == e_late_src_mem);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lock       <= 1'b0;
            r_sel        <= e_late_src_long;
            r_last_grant <= e_late_src_mem;
        end else begin
            r_lock <= late_wb_v_o && !late_wb_yumi_i;
            if (late_wb_v_o) r_sel <= w_sel;
            if (late_wb_yumi_i) r_last_grant <= w_sel;
        end
    end

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        late_wb_yumi_i |-> late_wb_v_o);
    a_long_one_rf: assert property (@(posedge clk_i) disable iff (reset_i)
        long_v_i |-> (long_ird_w_v_i ^ long_frd_w_v_i));
    a_mem_one_rf: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_v_i |-> (mem_ird_w_v_i ^ mem_frd_w_v_i));

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// tb_bp_be_late_wb_arbiter: directed scenario bench for the late writeback arbiter.
module tb_bp_be_late_wb_arbiter;
    import bp_be_pkg::*;

    logic        clk_i;
    logic        reset_i;
    logic        long_v_i;
    logic        long_ready_o;
    logic [4:0]  long_rd_addr_i;
    logic        long_ird_w_v_i;
    logic        long_frd_w_v_i;
    logic [63:0] long_data_i;
    logic        long_fflags_w_v_i;
    logic [4:0]  long_fflags_i;
    logic        mem_v_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_addr_i;
    logic        mem_ird_w_v_i;
    logic        mem_frd_w_v_i;
    logic [63:0] mem_data_i;
    logic        late_wb_v_o;
    logic [76:0] late_wb_pkt_o;
    logic        late_wb_yumi_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    bp_be_late_wb_arbiter dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .long_v_i          (long_v_i),
        .long_ready_o      (long_ready_o),
        .long_rd_addr_i    (long_rd_addr_i),
        .long_ird_w_v_i    (long_ird_w_v_i),
        .long_frd_w_v_i    (long_frd_w_v_i),
        .long_data_i       (long_data_i),
        .long_fflags_w_v_i (long_fflags_w_v_i),
        .long_fflags_i     (long_fflags_i),
        .mem_v_i           (mem_v_i),
        .mem_ready_o       (mem_ready_o),
        .mem_rd_addr_i     (mem_rd_addr_i),
        .mem_ird_w_v_i     (mem_ird_w_v_i),
        .mem_frd_w_v_i     (mem_frd_w_v_i),
        .mem_data_i        (mem_data_i),
        .late_wb_v_o       (late_wb_v_o),
        .late_wb_pkt_o     (late_wb_pkt_o),
        .late_wb_yumi_i    (late_wb_yumi_i),
        .busy_o            (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        long_v_i = 0; long_rd_addr_i = 0; long_ird_w_v_i = 0; long_frd_w_v_i = 0;
        long_data_i = 0; long_fflags_w_v_i = 0; long_fflags_i = 0;
        mem_v_i = 0; mem_rd_addr_i = 0; mem_ird_w_v_i = 0; mem_frd_w_v_i = 0;
        mem_data_i = 0; late_wb_yumi_i = 0;
    endtask

    task automatic drive_long(input logic [4:0] rd, input logic frd, input logic [63:0] d,
                              input logic fw, input logic [4:0] ff);
        long_v_i = 1; long_rd_addr_i = rd; long_ird_w_v_i = !frd; long_frd_w_v_i = frd;
        long_data_i = d; long_fflags_w_v_i = fw; long_fflags_i = ff;
    endtask

    task automatic drive_mem(input logic [4:0] rd, input logic [63:0] d);
        mem_v_i = 1; mem_rd_addr_i = rd; mem_ird_w_v_i = 1; mem_frd_w_v_i = 0; mem_data_i = d;
    endtask

    task automatic test_reset();
        idle();
        reset_i = 0;
        #2 reset_i = 1;
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v got %b want 0", late_wb_v_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_cmp++; if (long_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_long_ready got %b want 1", long_ready_o); end
        n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_mem_ready got %b want 1", mem_ready_o); end
        n_cmp++; if (late_wb_pkt_o !== '0) begin n_err++; $display("FAIL reset_pkt got %h want 0", late_wb_pkt_o); end
        #8 reset_i = 0;
        tick();
    endtask

    task automatic test_single_long();
        bp_be_wb_pkt_s exp;
        exp = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd5, rd_data: 64'h1234, fflags_w_v: 1'b1, fflags: 5'h3};
        drive_long(5'd5, 1'b0, 64'h1234, 1'b1, 5'h3);
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL single_bypass_v got %b want 0", late_wb_v_o); end
        tick();
        idle();
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b1) begin n_err++; $display("FAIL single_v got %b want 1", late_wb_v_o); end
        n_cmp++; if (late_wb_pkt_o !== exp) begin n_err++; $display("FAIL single_pkt got %h want %h", late_wb_pkt_o, exp); end
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy_o); end
        late_wb_yumi_i = 1;
        tick();
        late_wb_yumi_i = 0;
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL single_v_after got %b want 0", late_wb_v_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_after got %b want 0", busy_o); end
    endtask

    task automatic test_alternate();
        bp_be_wb_pkt_s exp_q [6];
        int ls = 0;
        int ms = 0;
        int got = 0;
        logic lf, mf;
        for (int k = 0; k < 3; k++) begin
            exp_q[2*k]   = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd2, rd_data: 64'h200 + 64'(k),
                             fflags_w_v: 1'b0, fflags: 5'h0};
            exp_q[2*k+1] = '{ird_w_v: 1'b0, frd_w_v: 1'b1, rd_addr: 5'd1, rd_data: 64'h100 + 64'(k),
                             fflags_w_v: 1'b1, fflags: 5'(k + 1)};
        end
        for (int c = 0; c < 20 && got < 6; c++) begin
            if (ls < 3) drive_long(5'd1, 1'b1, 64'h100 + 64'(ls), 1'b1, 5'(ls + 1));
            else long_v_i = 0;
            if (ms < 3) drive_mem(5'd2, 64'h200 + 64'(ms));
            else mem_v_i = 0;
            late_wb_yumi_i = late_wb_v_o;
            #1;
            lf = long_v_i && long_ready_o;
            mf = mem_v_i && mem_ready_o;
            if (late_wb_yumi_i) begin
                n_cmp++;
                if (late_wb_pkt_o !== exp_q[got]) begin
                    n_err++; $display("FAIL alt_pkt%0d got %h want %h", got, late_wb_pkt_o, exp_q[got]);
                end
                got++;
            end
            tick();
            ls += int'(lf);
            ms += int'(mf);
        end
        idle();
        n_cmp++; if (got !== 6) begin n_err++; $display("FAIL alt_count got %0d want 6", got); end
    endtask

    task automatic test_backpressure();
        bp_be_wb_pkt_s exp_m, exp_l;
        exp_m = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd7, rd_data: 64'h77, fflags_w_v: 1'b0, fflags: 5'h0};
        exp_l = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd9, rd_data: 64'h99, fflags_w_v: 1'b1, fflags: 5'h1f};
        drive_mem(5'd7, 64'h77);
        tick();
        mem_v_i = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) drive_long(5'd9, 1'b0, 64'h99, 1'b1, 5'h1f);
            else long_v_i = 0;
            #1;
            n_cmp++; if (late_wb_pkt_o !== exp_m) begin n_err++; $display("FAIL bp_hold%0d got %h want %h", c, late_wb_pkt_o, exp_m); end
            tick();
        end
        late_wb_yumi_i = 1;
        #1;
        n_cmp++; if (late_wb_pkt_o !== exp_m) begin n_err++; $display("FAIL bp_yumi_pkt got %h want %h", late_wb_pkt_o, exp_m); end
        tick();
        n_cmp++; if (late_wb_pkt_o !== exp_l) begin n_err++; $display("FAIL bp_next_long got %h want %h", late_wb_pkt_o, exp_l); end
        tick();
        late_wb_yumi_i = 0;
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL bp_drained_v got %b want 0", late_wb_v_o); end
    endtask

    task automatic test_lock();
        bp_be_wb_pkt_s exp_l, exp_m;
        exp_l = '{ird_w_v: 1'b0, frd_w_v: 1'b1, rd_addr: 5'd10, rd_data: 64'hA0, fflags_w_v: 1'b1, fflags: 5'h10};
        exp_m = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd11, rd_data: 64'hB0, fflags_w_v: 1'b0, fflags: 5'h0};
        drive_long(5'd10, 1'b1, 64'hA0, 1'b1, 5'h10);
        tick();
        long_v_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) drive_mem(5'd11, 64'hB0);
            else mem_v_i = 0;
            #1;
            n_cmp++; if (late_wb_pkt_o !== exp_l) begin n_err++; $display("FAIL lock_hold%0d got %h want %h", c, late_wb_pkt_o, exp_l); end
            tick();
        end
        late_wb_yumi_i = 1;
        #1;
        n_cmp++; if (late_wb_pkt_o !== exp_l) begin n_err++; $display("FAIL lock_yumi_pkt got %h want %h", late_wb_pkt_o, exp_l); end
        tick();
        n_cmp++; if (late_wb_pkt_o !== exp_m) begin n_err++; $display("FAIL lock_next_mem got %h want %h", late_wb_pkt_o, exp_m); end
        tick();
        late_wb_yumi_i = 0;
    endtask

    task automatic test_full();
        bp_be_wb_pkt_s e12, e13, e14;
        e12 = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd12, rd_data: 64'hC0, fflags_w_v: 1'b0, fflags: 5'h0};
        e13 = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd13, rd_data: 64'hC1, fflags_w_v: 1'b0, fflags: 5'h0};
        e14 = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd14, rd_data: 64'hC2, fflags_w_v: 1'b0, fflags: 5'h0};
        drive_mem(5'd12, 64'hC0);
        #1;
        n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready0 got %b want 1", mem_ready_o); end
        tick();
        drive_mem(5'd13, 64'hC1);
        #1;
        n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL full_ready1 got %b want 1", mem_ready_o); end
        tick();
        drive_mem(5'd14, 64'hC2);
        #1;
        n_cmp++; if (mem_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready2 got %b want 0", mem_ready_o); end
        tick();
        late_wb_yumi_i = 1;
        #1;
        n_cmp++; if (mem_ready_o !== 1'b0) begin n_err++; $display("FAIL full_deq_ready got %b want 0", mem_ready_o); end
        n_cmp++; if (late_wb_pkt_o !== e12) begin n_err++; $display("FAIL full_pkt12 got %h want %h", late_wb_pkt_o, e12); end
        tick();
        n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL full_accept3 got %b want 1", mem_ready_o); end
        n_cmp++; if (late_wb_pkt_o !== e13) begin n_err++; $display("FAIL full_pkt13 got %h want %h", late_wb_pkt_o, e13); end
        tick();
        mem_v_i = 0;
        #1;
        n_cmp++; if (late_wb_pkt_o !== e14) begin n_err++; $display("FAIL full_pkt14 got %h want %h", late_wb_pkt_o, e14); end
        tick();
        late_wb_yumi_i = 0;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL full_busy_end got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        bp_be_wb_pkt_s exp;
        exp = '{ird_w_v: 1'b1, frd_w_v: 1'b0, rd_addr: 5'd20, rd_data: 64'h2020, fflags_w_v: 1'b0, fflags: 5'h0};
        drive_long(5'd3, 1'b0, 64'h31, 1'b0, 5'h0);
        drive_mem(5'd4, 64'h41);
        tick();
        drive_long(5'd3, 1'b0, 64'h32, 1'b0, 5'h0);
        drive_mem(5'd4, 64'h42);
        tick();
        idle();
        #1;
        n_cmp++; if (long_ready_o !== 1'b0 || mem_ready_o !== 1'b0) begin
            n_err++; $display("FAIL mid_full got %b%b want 00", long_ready_o, mem_ready_o); end
        #2 reset_i = 1;
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_v got %b want 0", late_wb_v_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy_o); end
        n_cmp++; if (long_ready_o !== 1'b1 || mem_ready_o !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_ready got %b%b want 11", long_ready_o, mem_ready_o); end
        n_cmp++; if (late_wb_pkt_o !== '0) begin n_err++; $display("FAIL mid_rst_pkt got %h want 0", late_wb_pkt_o); end
        #2 reset_i = 0;
        tick();
        drive_mem(5'd20, 64'h2020);
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b0) begin n_err++; $display("FAIL mid_post_bypass got %b want 0", late_wb_v_o); end
        tick();
        mem_v_i = 0;
        #1;
        n_cmp++; if (late_wb_v_o !== 1'b1) begin n_err++; $display("FAIL mid_post_v got %b want 1", late_wb_v_o); end
        n_cmp++; if (late_wb_pkt_o !== exp) begin n_err++; $display("FAIL mid_post_pkt got %h want %h", late_wb_pkt_o, exp); end
        late_wb_yumi_i = 1;
        tick();
        late_wb_yumi_i = 0;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_post_busy got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single_long();
        test_alternate();
        test_backpressure();
        test_lock();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
